axilite_cfg_writer: RTL

//  AXI-lite master that feeds the AXI-lite slave front of a FINN IP register/parameter port.
//  - Consumes a stream of {addr,data} config words and issues one AXI-lite write per word, in order.
//  - Checks BRESP and counts write errors.
//  - Sits between an on-chip config source (DMA/ROM stream) and the IP's AXI-lite slave; no host CPU needed.

---
 rtl/axilite_cfg_writer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/axilite_cfg_writer.sv
// axilite_cfg_writer: AXI-lite master that turns a {addr,data} config stream
// into one AXI-lite write per word, in order, checking BRESP and counting
// completed writes and errors.
// Optional feature macro: AXILITE_CFG_WRITER_VERIFY_EN. When it is defined,
// each write is followed by a readback of the same address, and the read data
// is compared with the data that was written.
module axilite_cfg_writer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             aclk,
  input  logic                             rst,
  input  logic                             s_tvalid,
  output logic                             s_tready,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] s_tdata,
  input  logic                             s_tlast,
  output logic                             awvalid,
  input  logic                             awready,
  output logic [ADDR_WIDTH-1:0]            awaddr,
  output logic [2:0]                       awprot,
  output logic                             wvalid,
  input  logic                             wready,
  output logic [DATA_WIDTH-1:0]            wdata,
  output logic [DATA_WIDTH/8-1:0]          wstrb,
  input  logic                             bvalid,
  output logic                             bready,
  input  logic [1:0]                       bresp,
  output logic                             arvalid,
  input  logic                             arready,
  output logic [ADDR_WIDTH-1:0]            araddr,
  output logic [2:0]                       arprot,
  input  logic                             rvalid,
  output logic                             rready,
  input  logic [DATA_WIDTH-1:0]            rdata,
  input  logic [1:0]                       rresp,
  output logic                             busy,
  output logic                             done,
  output logic [CNT_WIDTH-1:0]             wr_cnt,
  output logic [CNT_WIDTH-1:0]             err_cnt
);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("axilite_cfg_writer: DATA_WIDTH must be 32 or 64");
  end

`ifdef AXILITE_CFG_WRITER_VERIFY_EN
  typedef enum logic [2:0] {IDLE, WRITE, RESP, RDADDR, RDDATA} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;
`endif

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   last_q, last_d;
  logic                   awvalid_q, awvalid_d;
  logic                   wvalid_q, wvalid_d;
  logic                   done_q, done_d;
  logic [CNT_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

  // State and datapath registers; reset clears valids at once, dropping any in-flight word.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      done_q    <= 1'b0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      last_q    <= last_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      done_q    <= done_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next-state: one outstanding transaction, AW and W retire independently.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    last_d    = last_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    done_d    = 1'b0;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (s_tvalid && s_tready) begin
          addr_d    = s_tdata[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
          data_d    = s_tdata[DATA_WIDTH-1:0];
          last_d    = s_tlast;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = RESP;
      end
      RESP: begin
        if (bvalid) begin
          wr_cnt_d = sat_inc(wr_cnt_q);
          if (bresp != 2'b00) err_cnt_d = sat_inc(err_cnt_q);
`ifdef AXILITE_CFG_WRITER_VERIFY_EN
          state_d = RDADDR;
`else
          state_d = IDLE;
          done_d  = last_q;
`endif
        end
      end
`ifdef AXILITE_CFG_WRITER_VERIFY_EN
      RDADDR: begin
        if (arready) state_d = RDDATA;
      end
      RDDATA: begin
        if (rvalid) begin
          if (rresp != 2'b00 || rdata != data_q) err_cnt_d = sat_inc(err_cnt_q);
          state_d = IDLE;
          done_d  = last_q;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign s_tready = (state_q == IDLE) && !rst;
  assign awvalid  = awvalid_q;
  assign awaddr   = addr_q;
  assign awprot   = 3'b000;
  assign wvalid   = wvalid_q;
  assign wdata    = data_q;
  assign wstrb    = '1;
  assign bready   = (state_q == RESP);
  assign arprot   = 3'b000;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign wr_cnt   = wr_cnt_q;
  assign err_cnt  = err_cnt_q;

`ifdef AXILITE_CFG_WRITER_VERIFY_EN
  assign arvalid = (state_q == RDADDR);
  assign araddr  = addr_q;
  assign rready  = (state_q == RDDATA);
`else
  assign arvalid = 1'b0;
  assign araddr  = '0;
  assign rready  = 1'b0;
  logic unused_rd;
  assign unused_rd = ^{arready, rvalid, rdata, rresp};
`endif

endmodule
